// File: rtl/way_select_plru.sv
// Hit detect and tree-PLRU victim select for a 4-way cache; registered one-hot way select.
// Optional WAY_SEL_MULTIHIT_CHK_EN adds o_multihit and suppresses PLRU update on multi-hit.
module way_select_plru #(
   parameter int TAG_WIDTH = 20,
   parameter int SET_BITS  = 6,
   parameter int WAYS      = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic [SET_BITS-1:0]       i_req_set,
   input  logic [TAG_WIDTH-1:0]      i_req_tag,
   input  logic [WAYS*TAG_WIDTH-1:0] i_way_tag,
   input  logic [WAYS-1:0]           i_way_vld,
   input  logic                      i_req_touch,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [WAYS-1:0]           o_sel,
   output logic                      o_hit,
`ifdef WAY_SEL_MULTIHIT_CHK_EN
   output logic                      o_multihit,
`endif
   output logic [SET_BITS-1:0]       o_set
);

   localparam int NSETS = 1 << SET_BITS;

   if (WAYS != 4) begin : g_ways_chk
      $error("way_select_plru: WAYS must be 4");
   end

   logic [WAYS-1:0]     hitvec;
   logic [WAYS-1:0]     hit_oh;
   logic [WAYS-1:0]     inv;
   logic [WAYS-1:0]     inv_oh;
   logic [WAYS-1:0]     plru_oh;
   logic [WAYS-1:0]     sel_d;
   logic                hit_d;
   logic                multihit;
   logic [2:0]          plru_cur;
   logic [2:0]          plru_upd;
   logic                accept;
   logic                upd_en;

   logic                rsp_valid_q;
   logic [WAYS-1:0]     sel_q;
   logic                hit_q;
   logic [SET_BITS-1:0] set_q;
   logic [NSETS-1:0][2:0] plru_q;

   for (genvar w = 0; w < WAYS; w++) begin : g_cmp
      assign hitvec[w] = i_way_vld[w] &&
                         (i_way_tag[w*TAG_WIDTH +: TAG_WIDTH] == i_req_tag);
   end

   assign o_req_ready = !rsp_valid_q || i_rsp_ready;
   assign accept      = i_req_valid && o_req_ready;

   always_comb begin
      hit_oh   = hitvec & (~hitvec + WAYS'(1));
      inv      = ~i_way_vld;
      inv_oh   = inv & (~inv + WAYS'(1));
      multihit = (hitvec & (hitvec - WAYS'(1))) != '0;
      hit_d    = |hitvec;
      plru_cur = plru_q[i_req_set];
      // b0 picks the pair, b1/b2 pick within the pair
      if (plru_cur[0]) begin
         plru_oh = plru_cur[2] ? 4'b1000 : 4'b0100;
      end else begin
         plru_oh = plru_cur[1] ? 4'b0010 : 4'b0001;
      end
      if (hit_d) begin
         sel_d = hit_oh;
      end else if (|inv) begin
         sel_d = inv_oh;
      end else begin
         sel_d = plru_oh;
      end
      plru_upd = plru_cur;
      unique case (1'b1)
         sel_d[0]: begin plru_upd[0] = 1'b1; plru_upd[1] = 1'b1; end
         sel_d[1]: begin plru_upd[0] = 1'b1; plru_upd[1] = 1'b0; end
         sel_d[2]: begin plru_upd[0] = 1'b0; plru_upd[2] = 1'b1; end
         sel_d[3]: begin plru_upd[0] = 1'b0; plru_upd[2] = 1'b0; end
         default: ;
      endcase
   end

`ifdef WAY_SEL_MULTIHIT_CHK_EN
   assign upd_en = accept && i_req_touch && !multihit;
`else
   assign upd_en = accept && i_req_touch;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_valid_q <= 1'b0;
         sel_q       <= '0;
         hit_q       <= 1'b0;
         set_q       <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         sel_q       <= sel_d;
         hit_q       <= hit_d;
         set_q       <= i_req_set;
      end else if (i_rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

`ifdef WAY_SEL_MULTIHIT_CHK_EN
   logic mh_q;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mh_q <= 1'b0;
      end else if (accept) begin
         mh_q <= multihit;
      end
   end
   assign o_multihit = mh_q;
`else
   logic unused_mh;
   assign unused_mh = multihit;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < NSETS; s++) begin
            plru_q[s] <= 3'b000;
         end
      end else if (upd_en) begin
         plru_q[i_req_set] <= plru_upd;
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_sel       = sel_q;
   assign o_hit       = hit_q;
   assign o_set       = set_q;

endmodule

// File: tb/tb_way_select_plru.sv
// Scoreboard bench for way_select_plru: a behavioural PLRU model predicts each
// response at accept time; responses are checked while pending and popped on consume.
module tb_way_select_plru;

`ifdef WAY_SEL_MULTIHIT_CHK_EN
   localparam bit MH_EN = 1'b1;
`else
   localparam bit MH_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] sel;
      logic       hit;
      logic [5:0] set;
      logic       mh;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic        req_ready;
   logic [5:0]  set;
   logic [19:0] tag;
   logic [79:0] way_tag;
   logic [3:0]  vld;
   logic        touch;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [3:0]  sel;
   logic        hit;
   logic [5:0]  rset;
`ifdef WAY_SEL_MULTIHIT_CHK_EN
   logic        mh;
`endif

   exp_t       sb[$];
   logic [2:0] m_plru[64];
   int         n_cmp;
   int         n_err;

   way_select_plru #(.TAG_WIDTH(20), .SET_BITS(6), .WAYS(4)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (valid),
      .o_req_ready (req_ready),
      .i_req_set   (set),
      .i_req_tag   (tag),
      .i_way_tag   (way_tag),
      .i_way_vld   (vld),
      .i_req_touch (touch),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_sel       (sel),
      .o_hit       (hit),
`ifdef WAY_SEL_MULTIHIT_CHK_EN
      .o_multihit  (mh),
`endif
      .o_set       (rset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, obs, exp, $time);
      end
   endtask

   task automatic model_accept();
      exp_t       e;
      int         cnt;
      int         way;
      logic [2:0] p;
      cnt = 0;
      way = -1;
      for (int w = 0; w < 4; w++) begin
         if (vld[w] && way_tag[w*20 +: 20] == tag) begin
            cnt++;
            if (way < 0) way = w;
         end
      end
      if (way < 0) begin
         for (int w = 0; w < 4; w++) begin
            if (!vld[w] && way < 0) way = w;
         end
      end
      p = m_plru[set];
      if (way < 0) way = p[0] ? (p[2] ? 3 : 2) : (p[1] ? 1 : 0);
      e.sel = 4'(1 << way);
      e.hit = cnt > 0;
      e.set = set;
      e.mh  = cnt > 1;
      if (touch && !(MH_EN && cnt > 1)) begin
         case (way)
            0: begin p[0] = 1'b1; p[1] = 1'b1; end
            1: begin p[0] = 1'b1; p[1] = 1'b0; end
            2: begin p[0] = 1'b0; p[2] = 1'b1; end
            default: begin p[0] = 1'b0; p[2] = 1'b0; end
         endcase
         m_plru[set] = p;
      end
      sb.push_back(e);
   endtask

   // Called at a negedge with inputs already driven; advances one cycle.
   task automatic cycle();
      exp_t f;
      bit   acc;
      #1;
      acc = valid && (sb.size() == 0 || rsp_ready);
      check("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
      check("req_ready", 32'(req_ready), 32'(sb.size() == 0 || rsp_ready));
      if (sb.size() != 0) begin
         f = sb[0];
         check("sel", 32'(sel), 32'(f.sel));
         check("hit", 32'(hit), 32'(f.hit));
         check("set", 32'(rset), 32'(f.set));
`ifdef WAY_SEL_MULTIHIT_CHK_EN
         check("multihit", 32'(mh), 32'(f.mh));
`endif
         if (rsp_ready) void'(sb.pop_front());
      end
      if (acc) model_accept();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic req(input logic [5:0] s, input logic [19:0] t,
                      input logic [19:0] t0, input logic [19:0] t1,
                      input logic [19:0] t2, input logic [19:0] t3,
                      input logic [3:0] v, input logic tch, input logic rr);
      valid     = 1'b1;
      set       = s;
      tag       = t;
      way_tag   = {t3, t2, t1, t0};
      vld       = v;
      touch     = tch;
      rsp_ready = rr;
      cycle();
   endtask

   task automatic idle(input int n);
      valid     = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      valid     = 1'b0;
      set       = '0;
      tag       = '0;
      way_tag   = '0;
      vld       = '0;
      touch     = 1'b0;
      rsp_ready = 1'b1;
      for (int s = 0; s < 64; s++) m_plru[s] = 3'b000;
      repeat (2) @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_set", 32'(rset), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // miss -> way 0, hit way 2, miss -> way 1
      req(6'd5, 20'hABCDE, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b1);
      req(6'd5, 20'hABCDE, 20'h1, 20'h2, 20'hABCDE, 20'h4, 4'hF, 1'b1, 1'b1);
      req(6'd5, 20'hABCDE, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b1);
      // invalid way 2 preferred over PLRU
      req(6'd7, 20'h55555, 20'h1, 20'h2, 20'h3, 20'h4, 4'b1011, 1'b1, 1'b1);
      idle(1);

      // backpressure: hold response for 3 cycles
      req(6'd9, 20'h00010, 20'h10, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         req(6'd9, 20'h00099, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b0);
      req(6'd9, 20'h00099, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b1);
      idle(1);

      // back-to-back misses in set 3
      for (int i = 0; i < 4; i++)
         req(6'd3, 20'hFFFFF, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b1);

      // reset while a response is held
      req(6'd3, 20'hFFFFF, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b0);
      valid = 1'b0;
      #1;
      check("pre_rst_valid", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(rsp_valid), 32'd0);
      check("async_rst_sel", 32'(sel), 32'd0);
      sb.delete();
      for (int s = 0; s < 64; s++) m_plru[s] = 3'b000;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      req(6'd3, 20'hFFFFF, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b1);

      // ways 1 and 3 both match, then a miss to observe the PLRU
      req(6'd11, 20'h12345, 20'h1, 20'h12345, 20'h3, 20'h12345, 4'hF, 1'b1, 1'b1);
      req(6'd11, 20'h77777, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b1);
      // probe only: no state change
      req(6'd12, 20'h77777, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b0, 1'b1);
      req(6'd12, 20'h77777, 20'h1, 20'h2, 20'h3, 20'h4, 4'hF, 1'b1, 1'b1);
      idle(1);

      // random traffic from a small tag pool
      for (int i = 0; i < 400; i++) begin
         valid     = 1'($urandom_range(0, 3) != 0);
         set       = 6'($urandom_range(0, 3));
         tag       = 20'($urandom_range(1, 4));
         for (int w = 0; w < 4; w++)
            way_tag[w*20 +: 20] = 20'($urandom_range(1, 6));
         vld       = 4'($urandom_range(0, 15) | (($urandom_range(0, 1) != 0) ? 15 : 0));
         touch     = 1'($urandom_range(0, 3) != 0);
         rsp_ready = 1'($urandom_range(0, 3) != 0);
         cycle();
      end
      idle(3);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
